// File: rtl/counter_checker.sv
// counter_checker
//   On-line checker that sits beside an up/down counter, snoops the same
//   stimulus the counter receives, runs a cycle-accurate golden model of it
//   and compares the model against the counter's outputs every cycle.
//
//   Handshake: none. All snooped inputs are sampled on the rising clk edge
//   exactly as the counter samples them. Results for a compared cycle appear
//   on the outputs one cycle later.
//
// Ports
//   clk          counter clock, rising edge
//   rst_n        asynchronous active-low reset, shared with the counter
//   chk_en       1 = compare this cycle (the model always tracks)
//   load_n       snooped load, active low
//   up_down      snooped direction, 1 = up
//   ce           snooped count enable
//   data_load    snooped load value
//   count_out    observed counter value
//   max_count    observed max flag
//   zero         observed zero flag
//   mismatch     one-cycle pulse per failing compare
//   err_field    {count, max, zero} bits that failed, valid with mismatch
//   err_cnt      saturating count of failing compares
//   chk_cnt      saturating count of compares performed
//   first_exp    model value at the first failure
//   first_got    count_out at the first failure
//   first_valid  first_exp/first_got captured
//   locked       error limit reached, checking stopped
//   dbg_state_o  current FSM state (debug)
module counter_checker #(
    parameter int WIDTH      = 4,
    parameter int ERR_W      = 8,
    parameter int MAX_ERRORS = 16,
    parameter int RESYNC     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             mismatch,
    output logic [2:0]       err_field,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic             first_valid,
    output logic             locked,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] base;
    logic             exp_max, exp_zero;
    logic [2:0]       fail;
    logic             active, any_fail;
    logic             hit_limit;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] chk_cnt_q, chk_cnt_d;
    logic             mismatch_q;
    logic [2:0]       err_field_q;
    logic [WIDTH-1:0] first_exp_q, first_got_q;
    logic             first_valid_q, locked_q;

    always_comb begin
        exp_max  = (m_q == '1);
        exp_zero = (m_q == '0);
        active   = (state_q == S_RUN) && chk_en;
        fail     = {count_out != m_q, max_count != exp_max, zero != exp_zero};
        any_fail = active && (fail != 3'b000);

        // Resync on a count mismatch only: the next model value follows the
        // observed count so a single bad step does not cascade.
        base = ((RESYNC != 0) && active && fail[2]) ? count_out : m_q;

        if (!load_n) begin
            m_d = data_load;
        end else if (ce) begin
            m_d = up_down ? base + WIDTH'(1) : base - WIDTH'(1);
        end else begin
            m_d = base;
        end

        chk_cnt_d = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + ERR_W'(1);
        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);

        // Lock only when an actual increment lands on the limit.
        hit_limit = (MAX_ERRORS != 0) && (err_cnt_q != '1)
                    && (32'(err_cnt_d) == 32'(MAX_ERRORS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            m_q           <= '0;
            mismatch_q    <= 1'b0;
            err_field_q   <= 3'b000;
            err_cnt_q     <= '0;
            chk_cnt_q     <= '0;
            first_exp_q   <= '0;
            first_got_q   <= '0;
            first_valid_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            // The model tracks in every state, including LOCK.
            m_q         <= m_d;
            mismatch_q  <= any_fail;
            err_field_q <= any_fail ? fail : 3'b000;

            case (state_q)
                S_INIT: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (active) begin
                        chk_cnt_q <= chk_cnt_d;
                    end
                    if (any_fail) begin
                        err_cnt_q <= err_cnt_d;
                        if (!first_valid_q) begin
                            first_exp_q   <= m_q;
                            first_got_q   <= count_out;
                            first_valid_q <= 1'b1;
                        end
                        if (hit_limit) begin
                            state_q  <= S_LOCK;
                            locked_q <= 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    state_q <= S_LOCK;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign mismatch    = mismatch_q;
    assign err_field   = err_field_q;
    assign err_cnt     = err_cnt_q;
    assign chk_cnt     = chk_cnt_q;
    assign first_exp   = first_exp_q;
    assign first_got   = first_got_q;
    assign first_valid = first_valid_q;
    assign locked      = locked_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a stand-in counter with fault hooks, a
// behavioural reference of the checker, a per-cycle compare process and a
// directed + randomized stimulus sequence.
module tb_counter_checker;

    localparam int W = 4;
    localparam int EW = 8;
    localparam int MAXE = 16;
    localparam int SAT = 255;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals ----------------
    logic         chk_en = 1'b0;
    logic         load_n = 1'b1;
    logic         up_down = 1'b1;
    logic         ce = 1'b0;
    logic [W-1:0] data_load = '0;
    logic [W-1:0] count_out;
    logic         max_count, zero;
    logic         mismatch;
    logic [2:0]   err_field;
    logic [EW-1:0] err_cnt, chk_cnt;
    logic [W-1:0] first_exp, first_got;
    logic         first_valid, locked;
    logic [1:0]   dbg_state;

    // fault hooks on the stand-in counter
    logic         glitch_en = 1'b0;
    logic [W-1:0] glitch_val = '0;
    logic         force_max = 1'b0;
    logic         force_zero = 1'b0;
    logic         stuck = 1'b0;

    counter_checker #(.WIDTH(W), .ERR_W(EW), .MAX_ERRORS(MAXE), .RESYNC(1)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .load_n(load_n),
        .up_down(up_down), .ce(ce), .data_load(data_load),
        .count_out(count_out), .max_count(max_count), .zero(zero),
        .mismatch(mismatch), .err_field(err_field), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .first_exp(first_exp), .first_got(first_got),
        .first_valid(first_valid), .locked(locked), .dbg_state_o(dbg_state)
    );

    // ---------------- stand-in counter ----------------
    logic [W-1:0] cnt_q;
    assign count_out = glitch_en ? glitch_val : cnt_q;
    assign max_count = (count_out == 4'hF) ^ force_max;
    assign zero      = (count_out == 4'h0) ^ force_zero;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (stuck) cnt_q <= cnt_q;
        else if (!load_n) cnt_q <= data_load;
        else if (ce) cnt_q <= up_down ? count_out + 4'd1 : count_out - 4'd1;
        else cnt_q <= count_out;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];   // {mismatch, err_field} expected one cycle later

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int m_m, err_m, chk_m, fe_m, fg_m, base_m, c_m;
    bit fv_m, lock_m, run_m, act_m;
    logic [2:0] f_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_m = 0; err_m = 0; chk_m = 0; fe_m = 0; fg_m = 0;
            fv_m = 0; lock_m = 0; run_m = 0;
            exp_q.delete();
        end else begin
            c_m   = int'(count_out);
            act_m = run_m && !lock_m && chk_en;
            f_m   = {c_m != m_m, max_count != (m_m == 15), zero != (m_m == 0)};
            if (act_m && f_m != 3'b000) begin
                exp_q.push_back({1'b1, f_m});
                if (err_m < SAT) begin
                    err_m = err_m + 1;
                    if (err_m == MAXE) lock_m = 1;
                end
                if (!fv_m) begin
                    fv_m = 1; fe_m = m_m; fg_m = c_m;
                end
            end else begin
                exp_q.push_back(4'b0000);
            end
            if (act_m) chk_m = (chk_m < SAT) ? chk_m + 1 : SAT;
            base_m = (act_m && f_m[2]) ? c_m : m_m;
            if (!load_n) m_m = int'(data_load);
            else if (ce) m_m = (base_m + (up_down ? 1 : 15)) % 16;
            else m_m = base_m;
            run_m = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic [3:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check("mismatch_field", {28'd0, mismatch, err_field}, {28'd0, e});
        check("err_cnt", 32'(err_cnt), err_m);
        check("chk_cnt", 32'(chk_cnt), chk_m);
        check("first_valid", 32'(first_valid), 32'(fv_m));
        check("first_exp", 32'(first_exp), fe_m);
        check("first_got", 32'(first_got), fg_m);
        check("locked", 32'(locked), 32'(lock_m));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic ld_n, input logic ud, input logic c,
                       input logic [W-1:0] d, input logic en);
        load_n = ld_n; up_down = ud; ce = c; data_load = d; chk_en = en;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rst_outs"},
              {11'd0, mismatch, err_field, err_cnt, chk_cnt, first_valid, locked},
              32'd0);
        check({tag, "_rst_first"}, {24'd0, first_exp, first_got}, 32'd0);
    endtask

    // reset mid-cycle, check outputs right away, release after the next negedge
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int saved_chk;

    initial begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // INIT cycle: no compare even with chk_en high
        cyc(1, 1, 0, 4'h0, 1);
        check("init_no_compare", 32'(chk_cnt), 32'd0);

        // Test 1: load A, count up through F
        cyc(0, 1, 0, 4'hA, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 4'h0, 1);
        check("t1_chk_cnt", 32'(chk_cnt), 32'd6);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_counter_at_F", 32'(count_out), 32'hF);

        // Test 2: wrap up and down
        cyc(0, 1, 0, 4'hF, 1);
        cyc(1, 1, 1, 4'h0, 1);
        cyc(1, 1, 0, 4'h0, 1);
        cyc(0, 0, 0, 4'h0, 1);
        cyc(1, 0, 1, 4'h0, 1);
        cyc(1, 0, 0, 4'h0, 1);
        check("t2_err_cnt", 32'(err_cnt), 32'd0);
        check("t2_chk_cnt", 32'(chk_cnt), 32'd12);

        // Test 3: counter jumps to 5 while the model expects 3
        cyc(0, 1, 0, 4'h3, 1);
        glitch_en = 1'b1; glitch_val = 4'h5;
        cyc(1, 1, 1, 4'h0, 1);
        glitch_en = 1'b0;
        check("t3_mismatch", 32'(mismatch), 32'd1);
        check("t3_field", 32'(err_field), 32'b100);
        check("t3_first", {23'd0, first_valid, first_exp, first_got}, {23'd0, 1'b1, 4'h3, 4'h5});
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 4'h0, 1);
        check("t3_resync_err", 32'(err_cnt), 32'd1);

        // Test 4: zero flag wrong at count 2, no resync
        cyc(0, 1, 0, 4'h2, 1);
        force_zero = 1'b1;
        cyc(1, 1, 0, 4'h0, 1);
        force_zero = 1'b0;
        check("t4_field", {31'd0, mismatch} << 3 | 32'(err_field), 32'b1001);
        check("t4_err_cnt", 32'(err_cnt), 32'd2);
        check("t4_first_kept", {24'd0, first_exp, first_got}, {24'd0, 4'h3, 4'h5});
        cyc(1, 1, 0, 4'h0, 1);
        check("t4_after_err", 32'(err_cnt), 32'd2);

        // Test 6a: reset mid-count
        cyc(1, 1, 1, 4'h0, 1);
        async_reset("t6a");
        cyc(1, 1, 1, 4'h0, 1);
        check("t6a_init_no_cmp", 32'(chk_cnt), 32'd0);

        // Randomized phase with occasional injected faults
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            glitch_en  = (r < 3);
            glitch_val = 4'($urandom_range(0, 15));
            force_max  = (r >= 3 && r < 5);
            force_zero = (r >= 5 && r < 7);
            cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) != 0));
        end
        glitch_en = 1'b0; force_max = 1'b0; force_zero = 1'b0;

        // Test 5: stuck counter drives the checker into LOCK
        async_reset("t5");
        cyc(1, 1, 0, 4'h0, 1);
        stuck = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 4'h0, 1);
        check("t5_locked", 32'(locked), 32'd1);
        check("t5_err_cnt", 32'(err_cnt), 32'd16);
        check("t5_chk_cnt", 32'(chk_cnt), 32'd17);
        saved_chk = int'(chk_cnt);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 4'h0, 1);
            check("t5_lock_quiet", 32'(mismatch), 32'd0);
        end
        check("t5_frozen", {16'd0, err_cnt, chk_cnt}, {16'd0, 8'd16, 8'(saved_chk)});

        // Test 6b: reset out of LOCK, one INIT cycle, then checking resumes
        async_reset("t6b");
        stuck = 1'b0;
        cyc(1, 1, 1, 4'h0, 1);
        check("t6b_init_no_cmp", 32'(chk_cnt), 32'd0);
        cyc(1, 1, 1, 4'h0, 1);
        check("t6b_resume", {16'd0, err_cnt, chk_cnt}, {16'd0, 8'd0, 8'd1});
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 4'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
